seq_alu: RTL and testbench

//  Parametrised successor of the single-cycle 32-bit ALU. Adds an iterative multiply/divide

---
 rtl/seq_alu.sv | 176 +++++++++++++++++
 tb/tb_seq_alu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked ALU with single-cycle logic/arith ops and an iterative shift-add multiplier
// and restoring divider. One operation in flight; the result is held until the consumer takes it.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        op_reg;
    logic [WIDTH-1:0]  opa_reg;   // multiplicand (mul) or dividend/quotient shifter (div)
    logic [WIDTH-1:0]  opb_reg;   // multiplier (mul) or divisor (div)
    logic [WIDTH-1:0]  acc_reg;   // partial product (mul) or partial remainder (div)
    logic [SH_W-1:0]   cnt_reg;

    logic              accept;
    logic              is_div;
    logic              multi_cycle;
    logic              last_iter;
    logic [SH_W-1:0]   sh;
    logic [WIDTH-1:0]  sum, diff;
    logic [WIDTH-1:0]  single_res;
    logic              single_ovf;
    logic [WIDTH-1:0]  mul_acc_next;
    logic [WIDTH:0]    rem_shift, rem_sub;
    logic              rem_fits;
    logic [WIDTH-1:0]  rem_next, quo_next, iter_res;

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign accept      = in_valid && in_ready;
    assign is_div      = (alu_control == OP_DIVU) || (alu_control == OP_REMU);
    // Division by zero is resolved immediately instead of iterating.
    assign multi_cycle = (alu_control == OP_MUL) || (is_div && (input_2 != '0));
    assign last_iter   = (cnt_reg == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = multi_cycle ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sh   = input_2[SH_W-1:0];
    assign sum  = input_1 + input_2;
    assign diff = input_1 - input_2;

    always_comb begin
        single_res = '0;
        single_ovf = 1'b0;
        case (alu_control)
            OP_ADD: begin
                single_res = sum;
                single_ovf = (input_1[WIDTH-1] == input_2[WIDTH-1]) && (sum[WIDTH-1] != input_1[WIDTH-1]);
            end
            OP_SUB: begin
                single_res = diff;
                single_ovf = (input_1[WIDTH-1] != input_2[WIDTH-1]) && (diff[WIDTH-1] != input_1[WIDTH-1]);
            end
            OP_AND:  single_res = input_1 & input_2;
            OP_OR:   single_res = input_1 | input_2;
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (input_1 < input_2)};
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(input_1) < $signed(input_2))};
            OP_XOR:  single_res = input_1 ^ input_2;
            OP_SLL:  single_res = input_1 << sh;
            OP_SRL:  single_res = input_1 >> sh;
            OP_SRA:  single_res = $signed(input_1) >>> sh;
            OP_DIVU: single_res = '1;
            OP_REMU: single_res = input_1;
            default: single_res = '0;
        endcase
    end

    // One multiplier bit or one quotient bit per BUSY cycle.
    assign mul_acc_next = acc_reg + (opb_reg[0] ? opa_reg : '0);
    assign rem_shift    = {acc_reg, opa_reg[WIDTH-1]};
    assign rem_sub      = rem_shift - {1'b0, opb_reg};
    assign rem_fits     = (rem_shift >= {1'b0, opb_reg});
    assign rem_next     = rem_fits ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next     = {opa_reg[WIDTH-2:0], rem_fits};

    always_comb begin
        iter_res = rem_next;
        if (op_reg == OP_MUL) begin
            iter_res = mul_acc_next;
        end else if (op_reg == OP_DIVU) begin
            iter_res = quo_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg   <= '0;
            opa_reg  <= '0;
            opb_reg  <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg  <= alu_control;
                        opa_reg <= input_1;
                        opb_reg <= input_2;
                        acc_reg <= '0;
                        cnt_reg <= '0;
                        if (!multi_cycle) begin
                            result   <= single_res;
                            zero     <= (single_res == '0);
                            overflow <= single_ovf;
                        end
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (op_reg == OP_MUL) begin
                        acc_reg <= mul_acc_next;
                        opa_reg <= opa_reg << 1;
                        opb_reg <= opb_reg >> 1;
                    end else begin
                        acc_reg <= rem_next;
                        opa_reg <= quo_next;
                    end
                    if (last_iter) begin
                        result   <= iter_res;
                        zero     <= (iter_res == '0);
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, randomized ops against an
// arithmetic reference model, result-hold and mid-divide reset sequences.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] input_1 = '0;
    logic [31:0] input_2 = '0;
    logic [3:0]  alu_control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .input_1(input_1), .input_2(input_2), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_z;
        logic        exp_ov;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the opcode definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output int lat);
        longint unsigned prod;
        r = '0;
        ov = 1'b0;
        lat = 0;
        case (op)
            4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = (a < b) ? 32'd1 : 32'd0;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = a ^ b;
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: r = $signed(a) >>> b[4:0];
            4'd10: begin
                prod = longint'(a) * longint'(b);
                r = prod[31:0];
                lat = 32;
            end
            4'd11: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = (b == 0) ? 0 : 32; end
            4'd12: begin r = (b == 0) ? a : a % b; lat = (b == 0) ? 0 : 32; end
            default: r = '0;
        endcase
    endfunction

    // Issues one op from IDLE (called #1 after a rising edge). lat counts rising edges
    // after the accepting edge until out_valid is seen: 0 for single-cycle ops.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic ov, output int lat);
        alu_control = op;
        input_1 = a;
        input_2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        input_1 = $urandom;
        input_2 = $urandom;
        alu_control = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        z = zero;
        ov = overflow;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_handshake_out_valid", 32'(out_valid), 32'd0);
        check("post_handshake_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r, er;
        logic        z, ov, eov;
        int          lat, elat;
        logic [3:0]  op;
        logic [31:0] a, b;
        bit          stable;

        vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 0};
        vecs[1]  = '{4'd1,  32'd5,         32'd5,         32'd0,         1'b1, 1'b0, 0};
        vecs[2]  = '{4'd4,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0, 0};
        vecs[3]  = '{4'd5,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0, 0};
        vecs[4]  = '{4'd10, 32'h0001_0003, 32'h0000_0007, 32'h0007_0015, 1'b0, 1'b0, 32};
        vecs[5]  = '{4'd11, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 32};
        vecs[6]  = '{4'd12, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 32};
        vecs[7]  = '{4'd11, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 0};
        vecs[8]  = '{4'd12, 32'd9,         32'd0,         32'd9,         1'b0, 1'b0, 0};
        vecs[9]  = '{4'd1,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1, 0};
        vecs[10] = '{4'd9,  32'hF000_0000, 32'd4,         32'hFF00_0000, 1'b0, 1'b0, 0};
        vecs[11] = '{4'd7,  32'd1,         32'h21,        32'd2,         1'b0, 1'b0, 0};
        vecs[12] = '{4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1'b1, 1'b0, 0};
        vecs[13] = '{4'd6,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 0};
        vecs[14] = '{4'd11, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 32};
        vecs[15] = '{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_result", result, 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, ov, lat);
            $display("vec %0d op=%0d a=%h b=%h -> result=%h zero=%0b ovf=%0b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, z, ov, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp_r);
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp_z));
            check($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            model(op, a, b, er, eov, elat);
            run_op(op, a, b, r, z, ov, lat);
            $display("rnd %0d op=%0d a=%h b=%h -> result=%h zero=%0b ovf=%0b lat=%0d",
                     i, op, a, b, r, z, ov, lat);
            check($sformatf("rnd%0d_result", i), r, er);
            check($sformatf("rnd%0d_zero", i), 32'(z), 32'(er == 32'd0));
            check($sformatf("rnd%0d_overflow", i), 32'(ov), 32'(eov));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end

        // Result held under back-pressure; new requests ignored while busy/done.
        alu_control = 4'd10;
        input_1 = 32'h0001_0003;
        input_2 = 32'h0000_0007;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_mul_latency", 32'(lat), 32'd32);
        alu_control = 4'd0;
        input_1 = 32'd1;
        input_2 = 32'd1;
        in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result !== 32'h0007_0015 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        $display("hold: result=%h out_valid=%0b in_ready=%0b", result, out_valid, in_ready);
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_result", result, 32'h0007_0015);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_queued_op", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a divide.
        alu_control = 4'd11;
        input_1 = 32'd100;
        input_2 = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("midreset: out_valid=%0b in_ready=%0b result=%h", out_valid, in_ready, result);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_no_result", 32'(out_valid), 32'd0);
        run_op(4'd12, 32'd100, 32'd7, r, z, ov, lat);
        $display("after reset remu 100/7 -> result=%h lat=%0d", r, lat);
        check("after_reset_result", r, 32'd2);
        check("after_reset_latency", 32'(lat), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
